// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider: FSM encoding and
// saturation constants used when the quotient cannot be represented.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Saturation value for a signed word of the given width: the largest
  // positive value, or the most negative one (low `width` bits are valid).
  function automatic logic [63:0] sat_value(input int unsigned width, input logic negative);
    logic [63:0] min_mag;
    min_mag = 64'd1 << (width - 1);
    return negative ? min_mag : (min_mag - 64'd1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// keep the trial difference when it does not go negative.
module div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem_in,
  input  logic         dvd_bit,
  input  logic [W-1:0] dmag,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // rem_in < dmag <= 2^(W-1), so the shifted value fits W+1 bits and the
  // difference fits W+1 bits signed; its top bit is the borrow.
  assign shifted = {rem_in, dvd_bit};
  assign diff    = shifted - {1'b0, dmag};
  assign q_bit   = ~diff[W];
  assign rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: magnitude restoring division, one quotient bit
// per clock, with sign fix-up and divide-by-zero/overflow saturation.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int DIN1_WIDTH = 32,
  parameter int DIN2_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic [DIN2_WIDTH-1:0] din2,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DIN1_WIDTH-1:0] dout,
  output logic [DIN2_WIDTH-1:0] rem,
  output logic                  dout_valid,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int N  = DIN1_WIDTH;
  localparam int M  = DIN2_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [N-1:0]  Q_MAX    = N'(sat_value(N, 1'b0));
  localparam logic [N-1:0]  Q_MIN    = N'(sat_value(N, 1'b1));
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

  state_t        state, next_state;
  logic [N-1:0]  dvd_q;      // dividend bits still to consume, quotient bits shifted in behind
  logic [M-1:0]  rem_q;
  logic [M-1:0]  dmag_q;
  logic [CW-1:0] cnt_q;
  logic          q_neg_q, r_neg_q, zero_q, ovf_q;

  logic          accept;
  logic [N-1:0]  din1_mag;
  logic [M-1:0]  din2_mag;
  logic [M-1:0]  step_rem;
  logic          step_bit;

  assign din_ready = (state == IDLE);
  assign accept    = din_valid & din_ready;

  // Unsigned magnitudes: negating the most negative value wraps to 2^(W-1),
  // which is exact when the result is read as unsigned.
  assign din1_mag = din1[N-1] ? -din1 : din1;
  assign din2_mag = din2[M-1] ? -din2 : din2;

  div_step #(.W(M)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[N-1]),
    .dmag    (dmag_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = CALC;
      CALC:    if (cnt_q == '0) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q   <= '0;
      rem_q   <= '0;
      dmag_q  <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dvd_q   <= din1_mag;
          rem_q   <= '0;
          dmag_q  <= din2_mag;
          cnt_q   <= CNT_LOAD;
          q_neg_q <= din1[N-1] ^ din2[M-1];
          r_neg_q <= din1[N-1];
          zero_q  <= (din2 == '0);
          ovf_q   <= (din1 == Q_MIN) && (din2 == '1);
        end
        CALC: begin
          rem_q <= step_rem;
          dvd_q <= {dvd_q[N-2:0], step_bit};
          cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Results are registered in FIX and held until the next FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout        <= '0;
      rem         <= '0;
      dout_valid  <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (state == FIX) begin
        dout_valid  <= 1'b1;
        div_by_zero <= zero_q;
        overflow    <= ovf_q;
        if (zero_q) begin
          dout <= r_neg_q ? Q_MIN : Q_MAX;
          rem  <= '0;
        end else if (ovf_q) begin
          dout <= Q_MAX;
          rem  <= '0;
        end else begin
          dout <= q_neg_q ? -dvd_q : dvd_q;
          rem  <= r_neg_q ? -rem_q : rem_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: directed corner cases,
// back-to-back accepts, randomized operands and mid-operation reset.
module tb_seq_signed_divider;

  localparam int N = 32;
  localparam int M = 16;
  localparam longint Q_MAX = (longint'(1) << (N - 1)) - 1;
  localparam longint Q_MIN = -(longint'(1) << (N - 1));

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] din1;
  logic [M-1:0] din2;
  logic         din_valid;
  logic         din_ready;
  logic [N-1:0] dout;
  logic [M-1:0] rem;
  logic         dout_valid;
  logic         div_by_zero;
  logic         overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  seq_signed_divider #(.DIN1_WIDTH(N), .DIN2_WIDTH(M)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din1        (din1),
    .din2        (din2),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .dout        (dout),
    .rem         (rem),
    .dout_valid  (dout_valid),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [63:0] sx1(input logic [N-1:0] v);
    return 64'($signed(v));
  endfunction

  function automatic logic signed [63:0] sx2(input logic [M-1:0] v);
    return 64'($signed(v));
  endfunction

  // Reference: truncating signed division with the saturation rules.
  function automatic void model(input longint a, input longint b,
                                output longint q, output longint r,
                                output bit dz, output bit ov);
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      dz = 1'b1;
      q  = (a >= 0) ? Q_MAX : Q_MIN;
      r  = 0;
    end else if (a == Q_MIN && b == -1) begin
      ov = 1'b1;
      q  = Q_MAX;
      r  = 0;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic rand_ops(output logic [N-1:0] a, output logic [M-1:0] b);
    int sa, sb;
    sa = $urandom_range(0, 9);
    sb = $urandom_range(0, 9);
    case (sa)
      0:       a = N'(Q_MIN);
      1:       a = N'($urandom_range(0, 400) - 200);
      default: a = N'($urandom);
    endcase
    case (sb)
      0:       b = '0;
      1:       b = '1;
      2, 3, 4: b = M'($urandom_range(0, 40) - 20);
      default: b = M'($urandom);
    endcase
  endtask

  // Compare the registered result against the model for operands a/b.
  task automatic check_result(input string tag, input logic [N-1:0] a, input logic [M-1:0] b);
    longint q, r;
    bit dz, ov;
    model(sx1(a), sx2(b), q, r, dz, ov);
    check({tag, "_q"},   sx1(dout), q);
    check({tag, "_r"},   sx2(rem), r);
    check({tag, "_dz"},  64'(div_by_zero), 64'(dz));
    check({tag, "_ov"},  64'(overflow), 64'(ov));
    if (!dz && !ov)
      check({tag, "_id"}, sx1(dout) * sx2(b) + sx2(rem), sx1(a));
  endtask

  task automatic run_op(input longint a, input longint b, input string tag);
    logic [N-1:0] av;
    logic [M-1:0] bv;
    int cyc;
    bit seen, ready_bad;
    av = N'(a);
    bv = M'(b);
    cyc = 0;
    @(negedge clk);
    while (!din_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!din_ready) begin
      check({tag, "_ready_timeout"}, 64'(din_ready), 64'd1);
      return;
    end
    din1 = av;
    din2 = bv;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din1 = N'($urandom);
    din2 = M'($urandom);
    cyc = 0;
    seen = 1'b0;
    ready_bad = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (dout_valid) seen = 1'b1;
      else if (din_ready) ready_bad = 1'b1;
    end
    check({tag, "_valid"}, 64'(seen), 64'd1);
    check({tag, "_lat"}, 64'(cyc), 64'(N + 1));
    check({tag, "_busy"}, 64'(ready_bad), 64'd0);
    check({tag, "_rdy"}, 64'(din_ready), 64'd1);
    check_result(tag, av, bv);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 64'(dout_valid), 64'd0);
    check({tag, "_hold"}, sx1(dout), sx1(dout) === 'x ? 64'sd0 : sx1(dout));
  endtask

  initial begin
    logic [N-1:0] qa[$];
    logic [M-1:0] qb[$];
    int acc_cyc[$];
    int cyc, got, n_acc;
    bit seen;

    rst_n = 1'b0;
    din_valid = 1'b0;
    din1 = '0;
    din2 = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(din_ready), 64'd1);
    check("rst_dout", sx1(dout), 0);
    check("rst_rem", sx2(rem), 0);
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_flags", 64'({div_by_zero, overflow}), 64'd0);
    rst_n = 1'b1;

    run_op(100, 7, "pp");
    run_op(-100, 7, "np");
    run_op(100, -7, "pn");
    run_op(-100, -7, "nn");
    run_op(5, 0, "dz_pos");
    run_op(-5, 0, "dz_neg");
    run_op(0, 0, "dz_zero");
    run_op(Q_MIN, -1, "ovf");
    run_op(Q_MIN, 1, "min_one");
    run_op(Q_MIN, -32768, "min_min");
    run_op(Q_MAX, -32768, "max_min");
    run_op(0, 5, "zero_num");

    // din_valid held high with operands changing every cycle.
    cyc = 0;
    got = 0;
    n_acc = 0;
    @(negedge clk);
    din_valid = 1'b1;
    while (got < 5 && cyc < 5 * (N + 2) + 60) begin
      if (n_acc < 5) begin
        rand_ops(din1, din2);
        if (din_ready) begin
          qa.push_back(din1);
          qb.push_back(din2);
          acc_cyc.push_back(cyc);
          n_acc++;
        end
      end else begin
        din_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (dout_valid) begin
        if (qa.size() == 0) check("b2b_spurious", 64'd1, 64'd0);
        else check_result("b2b", qa.pop_front(), qb.pop_front());
        got++;
      end
      @(negedge clk);
    end
    din_valid = 1'b0;
    check("b2b_count", 64'(got), 64'd5);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("b2b_interval", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(N + 2));

    for (int i = 0; i < 1200; i++) begin
      logic [N-1:0] ra;
      logic [M-1:0] rb;
      rand_ops(ra, rb);
      run_op(sx1(ra), sx2(rb), "rnd");
    end

    // Reset ten cycles into an operation.
    @(negedge clk);
    din1 = N'(100);
    din2 = M'(7);
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_ready", 64'(din_ready), 64'd1);
    check("arst_dout", sx1(dout), 0);
    check("arst_rem", sx2(rem), 0);
    check("arst_valid", 64'(dout_valid), 64'd0);
    check("arst_flags", 64'({div_by_zero, overflow}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (2 * N) begin
      @(posedge clk);
      #1;
      if (dout_valid) seen = 1'b1;
    end
    check("arst_no_valid", 64'(seen), 64'd0);
    run_op(1000, -3, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
